fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// - Instruction fetch stage of the 2-bit-opcode CPU: owns the PC, issues reads to instruction
//   memory over a req/ack handshake and holds the fetched word in a one-entry IF/ID buffer.
// - id_op feeds the control decoder; id_instr/id_pc feed register read and branch-target logic.
// - Accepts a redirect from the execute stage on a taken branch and squashes wrong-path fetches.
// PARAMETERS
// - PC_W      8   PC / instruction-memory address width (word addressed)
// - INSTR_W   8   instruction width; op field is instr[INSTR_W-1 -: 2]
// - RESET_PC  0   PC value loaded on reset
// PORTS
// - clk          in   1        rising-edge clock, sole clock domain
// - reset        in   1        asynchronous, active-high reset
// - imem_req     out  1        read request to instruction memory
// - imem_addr    out  PC_W     read address; stable while imem_req high
// - imem_ack     in   1        read data valid this cycle; may coincide with first req cycle
// - imem_rdata   in   INSTR_W  instruction word, sampled when imem_ack=1
// - redirect     in   1        taken branch, one-cycle pulse
// - redirect_pc  in   PC_W     branch target, valid with redirect
// - id_ready     in   1        decode can consume the buffer this cycle (0 = stall)
// - id_valid     out  1        buffer holds a valid instruction
// - id_instr     out  INSTR_W  buffered instruction
// - id_op        out  2        id_instr op field, to control decoder
// - id_pc        out  PC_W     address of the buffered instruction
// BEHAVIOUR
// - Reset: pc=RESET_PC, state=S_ISSUE, id_valid=0, id_instr=0, id_pc=0, req_addr=0.
//   imem_req=0 during reset. Reset mid-request abandons the transfer; any later ack is ignored.
// - buf_free = !id_valid | id_ready. Consume = id_valid & id_ready, which clears id_valid
//   unless the buffer is reloaded in the same cycle.
// - S_ISSUE: imem_req = buf_free & !redirect; imem_addr=pc; req_addr<=pc when req.
//   - req & ack: load buffer (id_valid=1, id_instr=rdata, id_pc=pc), pc<=pc+1, stay.
//   - req & !ack: go S_WAIT.
// - S_WAIT: imem_req=1, imem_addr=req_addr. The buffer is always empty here.
//   - ack: load buffer with id_pc=req_addr, pc<=pc+1, go S_ISSUE.
//   - redirect & ack: discard data, go S_ISSUE.
//   - redirect & !ack: go S_SQUASH.
// - S_SQUASH: imem_req=1, imem_addr=req_addr; ack discards data, go S_ISSUE.
// - Once raised, req is never retracted before ack, except by reset. One request outstanding max.
// - Redirect, any state: pc<=redirect_pc, id_valid<=0 (flush overrides consume/load).
//   Redirect in S_SQUASH reloads pc and stays in S_SQUASH.
// - Latency: with an ack in the same cycle, throughput is 1 instr/clk; the fetch is visible on
//   id_* the next cycle. An N-cycle memory gives N+1 clk per instruction.
// - PC arithmetic is modulo 2^PC_W: 2^PC_W-1 increments to 0, and redirect_pc is used as-is.
// - Stall: with id_valid=1 and id_ready=0, id_* hold and no new request is issued.
// STRUCTURE
// - Shared package cpu_pkg:
//   - opcodes OP_ADD=2'b00, OP_LW=2'b01, OP_SW=2'b10, OP_BEQ=2'b11
//   - instruction field positions
//   - fetch state encoding S_ISSUE/S_WAIT/S_SQUASH
// - One sub-module: if_id_buffer, the one-entry valid/instr/pc register with load, consume and flush.
// - FSM, pc and req_addr stay in fetch_unit.
// TESTING
// - Reset, ack same cycle as req, id_ready=1, mem[0..3]=8'h1B,8'h46,8'h89,8'hC1:
//   id_instr sequence 1B,46,89,C1 on consecutive clks; id_pc 0,1,2,3; id_op 0,1,2,3.
// - Ack delayed 3 cycles: imem_req stays high with addr stable for 3 clks; one instr per 4 clks.
// - id_ready=0 for 5 cycles while id_valid=1: id_* and pc frozen, imem_req=0; resumes in order.
// - Redirect to 8'h40 while in S_WAIT, ack 2 cycles later: that data never appears;
//   next id_pc=8'h40.
// - Redirect in the same cycle as ack: data discarded, id_valid=0 next clk, then id_pc=target.
//   Also: RESET_PC=8'hFF gives id_pc FF then 00.
// - Reset asserted mid-S_WAIT, ack arrives after release: ack ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, instruction fields and fetch states
package cpu_pkg;

  // Opcode values carried in the top two bits of every instruction
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_BEQ = 2'b11;

  // Op field is instr[INSTR_W-1 -: OP_W]
  localparam int OP_W = 2;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    S_ISSUE  = 2'd0,
    S_WAIT   = 2'd1,
    S_SQUASH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - one-entry IF/ID register with load, consume and flush
module if_id_buffer #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [INSTR_W-1:0] i_load_instr,
  input  logic [PC_W-1:0]    i_load_pc,
  input  logic               i_consume,
  input  logic               i_flush,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;

  // Valid bit: flush beats load, load beats consume; payload captured only on a kept load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= 1'b1;
      end else if (i_consume) begin
        r_valid <= 1'b0;
      end
      if (i_load && !i_flush) begin
        r_instr <= i_load_instr;
        r_pc    <= i_load_pc;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem handshake, IF/ID buffer
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [1:0]         id_op,
  output logic [PC_W-1:0]    id_pc
);

  fetch_state_t    r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_req_addr;

  logic            w_buf_free;
  logic            w_req;
  logic [PC_W-1:0] w_addr;
  logic            w_load;
  logic [PC_W-1:0] w_load_pc;
  logic            w_consume;

  assign w_buf_free = !id_valid || id_ready;
  assign w_consume  = id_valid && id_ready;

  // Request/address: new requests only from S_ISSUE, held requests in S_WAIT/S_SQUASH
  always_comb begin
    w_req  = 1'b0;
    w_addr = r_pc;
    case (r_state)
      S_ISSUE: begin
        w_req  = w_buf_free && !redirect;
        w_addr = r_pc;
      end
      S_WAIT, S_SQUASH: begin
        w_req  = 1'b1;
        w_addr = r_req_addr;
      end
      default: begin
        w_req  = 1'b0;
        w_addr = r_pc;
      end
    endcase
    if (reset) begin
      w_req = 1'b0;
    end
  end

  // Squashed data (S_SQUASH, or a redirect arriving with the ack) never reaches the buffer
  assign w_load    = w_req && imem_ack && !redirect && (r_state != S_SQUASH);
  assign w_load_pc = (r_state == S_ISSUE) ? r_pc : r_req_addr;

  assign imem_req  = w_req;
  assign imem_addr = w_addr;

  // Fetch sequencer, PC and latched request address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_ISSUE;
      r_pc       <= RESET_PC;
      r_req_addr <= '0;
    end else begin
      if (redirect) begin
        r_pc <= redirect_pc;
      end else if (w_load) begin
        r_pc <= r_pc + 1'b1;
      end
      case (r_state)
        S_ISSUE: begin
          if (w_req) begin
            r_req_addr <= r_pc;
            if (!imem_ack) begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            r_state <= S_ISSUE;
          end else if (redirect) begin
            r_state <= S_SQUASH;
          end
        end
        S_SQUASH: begin
          if (imem_ack) begin
            r_state <= S_ISSUE;
          end
        end
        default: r_state <= S_ISSUE;
      endcase
    end
  end

  if_id_buffer #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_buffer (
    .clk          (clk),
    .rst          (reset),
    .i_load       (w_load),
    .i_load_instr (imem_rdata),
    .i_load_pc    (w_load_pc),
    .i_consume    (w_consume),
    .i_flush      (redirect),
    .o_valid      (id_valid),
    .o_instr      (id_instr),
    .o_pc         (id_pc)
  );

  assign id_op = id_instr[INSTR_W-1 -: OP_W];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       id_ready;
  logic       id_valid;
  logic [7:0] id_instr;
  logic [1:0] id_op;
  logic [7:0] id_pc;

  logic       req2;
  logic [7:0] addr2;
  logic [7:0] rdata2;
  logic       valid2;
  logic [7:0] instr2;
  logic [1:0] op2;
  logic [7:0] pc2;

  logic [7:0] mem [256];
  int         lat;
  logic       ack_now;
  int         mem_cnt;

  int         n_chk = 0;
  int         n_bad = 0;
  logic       mon_on = 1'b0;
  logic [7:0] exp_pc;
  logic       prev_pend;
  logic [7:0] prev_addr;
  int         n_consume = 0;

  always #5 clk = ~clk;

  // Memory responder: acks once a request has waited lat cycles, or when forced
  assign imem_ack   = imem_req && ((mem_cnt >= lat) || ack_now);
  assign imem_rdata = mem[imem_addr];
  assign rdata2     = mem[addr2];

  always @(posedge clk or posedge reset) begin
    if (reset) mem_cnt <= 0;
    else if (imem_req && !imem_ack) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  end

  fetch_unit #(.PC_W(8), .INSTR_W(8), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_op(id_op), .id_pc(id_pc)
  );

  fetch_unit #(.PC_W(8), .INSTR_W(8), .RESET_PC(8'hFF)) u_dut_ff (
    .clk(clk), .reset(reset),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(1'b1), .imem_rdata(rdata2),
    .redirect(1'b0), .redirect_pc(8'h00), .id_ready(1'b1),
    .id_valid(valid2), .id_instr(instr2), .id_op(op2), .id_pc(pc2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Reference model: program order from reset/redirect targets, plus handshake rules
  always @(negedge clk) begin
    #2;
    if (mon_on) begin
      if (reset) begin
        exp_pc    = 8'h00;
        prev_pend = 1'b0;
      end else begin
        if (prev_pend) begin
          chk("req_held", 32'(imem_req), 32'(1));
          chk("addr_held", 32'(imem_addr), 32'(prev_addr));
        end
        if (id_valid && !id_ready) chk("stall_no_req", 32'(imem_req), 32'(0));
        if (redirect) begin
          exp_pc = redirect_pc;
        end else if (id_valid && id_ready) begin
          chk("seq_pc", 32'(id_pc), 32'(exp_pc));
          chk("seq_instr", 32'(id_instr), 32'(mem[exp_pc]));
          chk("seq_op", 32'(id_op), 32'(mem[exp_pc][7:6]));
          exp_pc = exp_pc + 8'd1;
          n_consume++;
        end
        prev_pend = imem_req && !imem_ack;
        prev_addr = imem_addr;
      end
    end
  end

  initial begin
    logic [7:0] seq [4];
    logic [7:0] fz_pc, fz_instr, a_hold, last_addr, fz_next;
    int cnt_v, cnt_r, cnt_chg, base_consume;

    seq = '{8'h1B, 8'h46, 8'h89, 8'hC1};
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) mem[i] = seq[i];
    reset = 1'b1; redirect = 1'b0; redirect_pc = 8'h00; id_ready = 1'b1;
    lat = 0; ack_now = 1'b0; exp_pc = 8'h00; prev_pend = 1'b0; prev_addr = 8'h00;
    mon_on = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #3;
    chk("rst_req", 32'(imem_req), 32'(0));
    chk("rst_valid", 32'(id_valid), 32'(0));
    chk("rst_instr", 32'(id_instr), 32'(0));
    chk("rst_pc", 32'(id_pc), 32'(0));
    chk("rst_req2", 32'(req2), 32'(0));

    // Zero-wait memory: one instruction per clock from address 0
    nxt(); reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nxt(); settle();
      chk("s1_valid", 32'(id_valid), 32'(1));
      chk("s1_instr", 32'(id_instr), 32'(seq[k]));
      chk("s1_pc", 32'(id_pc), 32'(k));
      chk("s1_op", 32'(id_op), 32'(k));
      if (k == 0) begin
        chk("ff_pc0", 32'(pc2), 32'(8'hFF));
        chk("ff_instr0", 32'(instr2), 32'(mem[255]));
        chk("ff_op0", 32'(op2), 32'(mem[255][7:6]));
      end
      if (k == 1) begin
        chk("ff_pc1", 32'(pc2), 32'(0));
        chk("ff_valid1", 32'(valid2), 32'(1));
      end
    end

    // Three-cycle memory: four clocks per instruction, request held steady
    nxt(); lat = 3; settle();
    last_addr = imem_addr;
    cnt_v = 0; cnt_r = 0; cnt_chg = 0;
    for (int k = 0; k < 16; k++) begin
      nxt(); settle();
      cnt_v += int'(id_valid);
      cnt_r += int'(imem_req);
      if (imem_addr != last_addr) cnt_chg++;
      last_addr = imem_addr;
    end
    chk("lat3_valid_cnt", 32'(cnt_v), 32'(4));
    chk("lat3_req_cnt", 32'(cnt_r), 32'(16));
    chk("lat3_addr_chg", 32'(cnt_chg), 32'(4));

    // Decode stall for five cycles
    nxt(); lat = 0;
    repeat (2) nxt();
    nxt(); id_ready = 1'b0; settle();
    chk("stall_valid", 32'(id_valid), 32'(1));
    chk("stall_req0", 32'(imem_req), 32'(0));
    fz_pc = id_pc; fz_instr = id_instr; fz_next = fz_pc + 8'd1;
    for (int k = 0; k < 4; k++) begin
      nxt(); settle();
      chk("stall_pc", 32'(id_pc), 32'(fz_pc));
      chk("stall_instr", 32'(id_instr), 32'(fz_instr));
      chk("stall_req", 32'(imem_req), 32'(0));
      chk("stall_fetch_pc", 32'(imem_addr), 32'(fz_next));
    end
    nxt(); id_ready = 1'b1; settle();
    chk("resume_req", 32'(imem_req), 32'(1));
    nxt(); settle();
    chk("resume_pc", 32'(id_pc), 32'(fz_next));

    // Redirect while waiting; the late ack two cycles on is dropped
    nxt(); lat = 99; settle();
    a_hold = imem_addr;
    chk("w_req", 32'(imem_req), 32'(1));
    nxt(); redirect = 1'b1; redirect_pc = 8'h40; settle();
    chk("w_redir_req", 32'(imem_req), 32'(1));
    chk("w_redir_addr", 32'(imem_addr), 32'(a_hold));
    nxt(); redirect = 1'b0; settle();
    chk("sq_valid", 32'(id_valid), 32'(0));
    chk("sq_addr", 32'(imem_addr), 32'(a_hold));
    nxt(); ack_now = 1'b1; settle();
    nxt(); ack_now = 1'b0; lat = 0; settle();
    chk("sq_drop_valid", 32'(id_valid), 32'(0));
    chk("sq_new_addr", 32'(imem_addr), 32'(8'h40));
    nxt(); settle();
    chk("tgt40_valid", 32'(id_valid), 32'(1));
    chk("tgt40_pc", 32'(id_pc), 32'(8'h40));
    chk("tgt40_instr", 32'(id_instr), 32'(mem[8'h40]));

    // Redirect coinciding with the ack
    nxt(); lat = 99; settle();
    nxt(); redirect = 1'b1; redirect_pc = 8'h80; ack_now = 1'b1; settle();
    nxt(); redirect = 1'b0; ack_now = 1'b0; lat = 0; settle();
    chk("coinc_valid", 32'(id_valid), 32'(0));
    nxt(); settle();
    chk("coinc_pc", 32'(id_pc), 32'(8'h80));
    chk("coinc_valid2", 32'(id_valid), 32'(1));

    // PC wraps from FF to 00
    nxt(); redirect = 1'b1; redirect_pc = 8'hFF; settle();
    chk("redir_no_req", 32'(imem_req), 32'(0));
    nxt(); redirect = 1'b0; settle();
    chk("wrap_flush", 32'(id_valid), 32'(0));
    nxt(); settle();
    chk("wrap_ff", 32'(id_pc), 32'(8'hFF));
    nxt(); settle();
    chk("wrap_00", 32'(id_pc), 32'(8'h00));

    // Reset in the middle of a wait; the ack after release starts fresh at address 0
    nxt(); lat = 3; settle();
    nxt(); settle();
    chk("mid_wait_req", 32'(imem_req), 32'(1));
    nxt(); reset = 1'b1; settle();
    chk("mid_rst_req", 32'(imem_req), 32'(0));
    chk("mid_rst_valid", 32'(id_valid), 32'(0));
    nxt(); settle();
    nxt(); reset = 1'b0; ack_now = 1'b1; settle();
    chk("restart_addr", 32'(imem_addr), 32'(0));
    nxt(); ack_now = 1'b0; lat = 0; settle();
    chk("restart_pc", 32'(id_pc), 32'(0));
    chk("restart_instr", 32'(id_instr), 32'(8'h1B));

    // Randomized traffic against the reference model
    base_consume = n_consume;
    for (int k = 0; k < 3000; k++) begin
      nxt();
      id_ready = ($urandom % 4) != 0;
      lat = int'($urandom % 4);
      if (($urandom % 20) == 0) begin
        redirect = 1'b1;
        redirect_pc = 8'($urandom);
      end else begin
        redirect = 1'b0;
      end
    end
    nxt(); redirect = 1'b0;
    chk("rand_progress", 32'((n_consume - base_consume) > 300), 32'(1));

    nxt();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
